// File: rtl/arith_isqrt.sv
// arith_isqrt: radix-2 digit-recurrence integer square root, one root bit per cycle
module arith_isqrt #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W+1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W:0]     out_root,
    output logic [W+1:0]   out_rem,
    output logic           out_exact
);
    localparam int CW = $clog2(W + 2);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t         r_state;
    logic [2*W+1:0] r_sh;
    logic [W:0]     r_root;
    logic [W+2:0]   r_rem;
    logic [CW-1:0]  r_cnt;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [W:0]     r_out_root;
    logic [W+1:0]   r_out_rem;
    logic           r_out_exact;
    logic [W+2:0]   w_rem_sh;
    logic [W+2:0]   w_trial;
    logic           w_ge;
    logic [W+2:0]   w_rem_nx;
    logic [W:0]     w_root_nx;
    // Partial root stays below W bits and partial remainder below W+1 bits until the last step
    always_comb begin
        w_rem_sh  = {r_rem[W:0], r_sh[2*W+1 -: 2]};
        w_trial   = {1'b0, r_root[W-1:0], 2'b01};
        w_ge      = w_rem_sh >= w_trial;
        w_rem_nx  = w_ge ? w_rem_sh - w_trial : w_rem_sh;
        w_root_nx = {r_root[W-1:0], w_ge};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sh        <= '0;
            r_root      <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_root  <= '0;
            r_out_rem   <= '0;
            r_out_exact <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_sh       <= in_data;
                    r_root     <= '0;
                    r_rem      <= '0;
                    r_cnt      <= CW'(W + 1);
                    r_in_ready <= 1'b0;
                    r_state    <= CALC;
                end
                CALC: begin
                    r_sh   <= {r_sh[2*W-1:0], 2'b00};
                    r_rem  <= w_rem_nx;
                    r_root <= w_root_nx;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_out_root  <= w_root_nx;
                        r_out_rem   <= w_rem_nx[W+1:0];
                        r_out_exact <= w_rem_nx == '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_root  = r_out_root;
    assign out_rem   = r_out_rem;
    assign out_exact = r_out_exact;
endmodule
